// File: rtl/seq_mult_pkg.sv
// Shared types, segment codes and helpers for the sequential multiplier display.
// Optional feature macro used by the top: LEADING_ZERO_BLANK_EN.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    BCD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Smallest digit count whose decimal range covers (2^w-1)^2.
  function automatic int min_digits(input int width);
    longint unsigned mx;
    longint unsigned p;
    int d;
    mx = (64'd1 << width) - 64'd1;
    mx = mx * mx;
    p  = 64'd1;
    d  = 0;
    while (p <= mx) begin
      p = p * 64'd10;
      d++;
    end
    return d;
  endfunction

  // Double-dabble nibble correction ahead of the shift.
  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/seven_seg_dec.sv
// One BCD nibble to active-low {g,f,e,d,c,b,a}.
// Non-decimal nibbles show a dash.
module seven_seg_dec
  import seq_mult_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Nibble to segment lookup.
  always_comb begin
    seg = SEG_DASH;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seq_multiplier_display.sv
// Shift-add multiplier with sequential double-dabble and 7-seg output.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seq_multiplier_display
  import seq_mult_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic                  busy,
  output logic                  done,
  output logic [2*WIDTH-1:0]    product,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int PW = 2 * WIDTH;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(PW + 1);

  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("DIGITS too small to display WIDTH x WIDTH product");
  end

  state_t         state;
  logic [PW-1:0]  mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]  acc;
  logic [PW-1:0]  bin;
  logic [BW-1:0]  bcd_w;
  logic [BW-1:0]  bcd_q;
  logic [CW-1:0]  cnt;

  logic [PW-1:0]  acc_nxt;
  logic [BW-1:0]  bcd_adj;
  logic [BW-1:0]  bcd_shift;
  logic           unused_bcd_msb;

  // Next accumulator value for one shift-add step.
  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = acc + mcand;
  end

  // Add-3 correction then shift in the next binary MSB.
  always_comb begin
    bcd_adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      bcd_adj[4*k +: 4] = dd_adj(bcd_w[4*k +: 4]);
    end
    bcd_shift = {bcd_adj[BW-2:0], bin[PW-1]};
  end

  // Top BCD bit cannot be set given the digit-count check.
  assign unused_bcd_msb = bcd_adj[BW-1];

  assign busy = (state == MUL) || (state == BCD);
  assign done = (state == DONE);

  // Control FSM and datapath; outputs load only at the end of BCD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      bin     <= '0;
      bcd_w   <= '0;
      bcd_q   <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL;
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bin   <= acc_nxt;
            bcd_w <= '0;
            cnt   <= '0;
            state <= BCD;
          end
        end
        BCD: begin
          bcd_w <= bcd_shift;
          bin   <= bin << 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(PW - 1)) begin
            bcd_q   <= bcd_shift;
            product <= acc;
            cnt     <= '0;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank;

  // Blank every digit above the highest non-zero one; digit 0 stays lit.
  always_comb begin : blank_c
    logic lead;
    lead  = 1'b1;
    blank = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lead     = lead & (bcd_q[4*k +: 4] == 4'd0);
      blank[k] = lead;
    end
  end
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    logic [6:0] seg;

    seven_seg_dec u_dec (
      .bcd (bcd_q[4*k +: 4]),
      .seg (seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign hex[7*k +: 7] = blank[k] ? SEG_BLANK : seg;
`else
    assign hex[7*k +: 7] = seg;
`endif
  end

endmodule

// File: tb/tb_seq_multiplier_display.sv
// Scoreboard bench for seq_multiplier_display.
// Expected product/hex queued at start, checked on done.
module tb_seq_multiplier_display;

  localparam int WIDTH  = 4;
  localparam int DIGITS = 3;
  localparam int PW     = 2 * WIDTH;
  localparam int HW     = 7 * DIGITS;
  localparam int LAT    = 3 * WIDTH + 1;

  typedef struct {
    logic [PW-1:0] p;
    logic [HW-1:0] h;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] ia;
  logic [WIDTH-1:0] ib;
  logic             busy;
  logic             done;
  logic [PW-1:0]    product;
  logic [HW-1:0]    hex;

  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [PW-1:0] last_p;
  logic [HW-1:0] last_h;

  seq_multiplier_display #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (ia),
    .b       (ib),
    .busy    (busy),
    .done    (done),
    .product (product),
    .hex     (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [HW-1:0] hex_of(input int v);
    logic [HW-1:0] r;
    logic [6:0]    s;
    int            pw;
    r  = '0;
    pw = 1;
    for (int k = 0; k < DIGITS; k++) begin
      s = seg_of((v / pw) % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && v < pw) s = 7'b1111111;
`endif
      r[7*k +: 7] = s;
      pw = pw * 10;
    end
    return r;
  endfunction

  task automatic push(input int a, input int b);
    exp_t e;
    e.p = PW'(a * b);
    e.h = hex_of(a * b);
    sb.push_back(e);
    last_p = e.p;
    last_h = e.h;
  endtask

  // Compare every done pulse against the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexp_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        check("product", 64'(product), 64'(e.p));
        check("hex", 64'(hex), 64'(e.h));
      end
    end
  end

  task automatic run_op(input int a, input int b);
    logic [PW-1:0] hp;
    logic [HW-1:0] hh;
    int lat;
    int bc;
    hp = last_p;
    hh = last_h;
    @(negedge clk);
    ia    = WIDTH'(a);
    ib    = WIDTH'(b);
    start = 1'b1;
    push(a, b);
    @(posedge clk);
    #1;
    start = 1'b0;
    ia    = ~ia;
    ib    = ~ib;
    lat   = 1;
    bc    = 0;
    while (!done && lat < 4 * LAT) begin
      if (busy) bc++;
      if (lat == WIDTH + 2) begin
        check("hold_p", 64'(product), 64'(hp));
        check("hold_h", 64'(hex), 64'(hh));
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(LAT));
    check("busy_cycles", 64'(bc), 64'(3 * WIDTH));
    @(posedge clk);
    #1;
    check("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cyc;
    int first;
    bit got2;

    rst_n  = 1'b0;
    start  = 1'b0;
    ia     = '0;
    ib     = '0;
    last_p = '0;
    last_h = hex_of(0);

    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_hex", 64'(hex), 64'(hex_of(0)));
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 0);
    run_op(15, 15);
    run_op(9, 1);

    // Start pulse mid-operation must be ignored.
    @(negedge clk);
    ia    = 4'd3;
    ib    = 4'd5;
    start = 1'b1;
    push(3, 5);
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 4 * LAT) begin
      if (lat == 4) begin
        ia    = 4'd7;
        ib    = 4'd7;
        start = 1'b1;
      end else if (lat == 5) begin
        start = 1'b0;
        ia    = 4'd1;
        ib    = 4'd2;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check("ign_latency", 64'(lat), 64'(LAT));
    repeat (2 * LAT) @(posedge clk);
    check("ign_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    ia    = 4'd12;
    ib    = 4'd11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_product", 64'(product), 64'd0);
    check("mid_rst_hex", 64'(hex), 64'(hex_of(0)));
    last_p = '0;
    last_h = hex_of(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * LAT) @(posedge clk);
    run_op(2, 3);

    // Start held high: back-to-back operations.
    @(negedge clk);
    ia    = 4'd5;
    ib    = 4'd6;
    start = 1'b1;
    push(5, 6);
    @(posedge clk);
    #1;
    ia    = 4'd13;
    ib    = 4'd11;
    push(13, 11);
    cyc   = 1;
    first = -1;
    got2  = 1'b0;
    while (!got2 && cyc < 6 * LAT) begin
      if (done) begin
        if (first < 0) begin
          first = cyc;
        end else begin
          check("b2b_period", 64'(cyc - first), 64'(3 * WIDTH + 2));
          got2  = 1'b1;
          start = 1'b0;
        end
      end
      if (!got2) begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    start = 1'b0;
    check("b2b_seen", 64'(got2), 64'd1);
    repeat (3) @(posedge clk);

    for (int i = 0; i < 4; i++) begin
      run_op($urandom_range(0, 15), $urandom_range(0, 15));
    end

    repeat (2 * LAT) @(posedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
